// File: rtl/dmem_pkg.sv
// dmem_pkg
//   Shared definitions for the data-memory port master: default address and
//   word widths, the burst-length field width and the controller state type.
package dmem_pkg;

  localparam int N_DEF  = 17;  // request/response data width
  localparam int AW_DEF = 12;  // memory address width
  localparam int DW_DEF = 12;  // memory word width
  localparam int LEN_W  = 4;   // burst length field width (length minus 1)

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WRITE      = 2'd1,
    RD_ISSUE   = 2'd2,
    RD_CAPTURE = 2'd3
  } dmem_state_t;

endpackage

// File: rtl/dmem_addr_gen.sv
// dmem_addr_gen
//   Burst address incrementer and beat counter for the data-memory port
//   master. Used only when DMEM_BURST_EN is defined.
//
//   clk, rst_n   clock, asynchronous active-low reset
//   start        load accepted: load start address and burst length
//   start_addr   first address of the burst
//   len          burst length minus 1
//   adv          one beat issued this cycle; step to the next address
//   next_addr    address of the following beat (wraps modulo 2^AW)
//   last         the beat currently being issued is the final one
module dmem_addr_gen
  import dmem_pkg::*;
#(
  parameter int AW = AW_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [AW-1:0]    start_addr,
  input  logic [LEN_W-1:0] len,
  input  logic             adv,
  output logic [AW-1:0]    next_addr,
  output logic             last
);

  logic [LEN_W-1:0] beats_left;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      next_addr  <= '0;
      beats_left <= '0;
    end else if (start) begin
      // The first address goes out directly from the request, so the
      // incrementer is already one ahead.
      next_addr  <= start_addr + AW'(1);
      beats_left <= len;
    end else if (adv && (beats_left != '0)) begin
      next_addr  <= next_addr + AW'(1);
      beats_left <= beats_left - LEN_W'(1);
    end
  end

  assign last = (beats_left == '0);

endmodule

// File: rtl/dmem_port_master.sv
// dmem_port_master
//   Core-side initiator for one data-memory port. Takes load/store requests
//   over a valid/ready handshake, drives the memory write_en/addr/datain,
//   captures the registered dataout and returns it as a one-cycle pulse.
//
//   Optional feature macro: DMEM_BURST_EN (adds req_len and burst loads).
//
//   clk, rst_n       clock, asynchronous active-low reset
//   req_valid/ready  request handshake (ready only in IDLE)
//   req_write        1 = store, 0 = load
//   req_addr         word address
//   req_wdata        store data (low DW bits reach memory)
//   req_len          burst length minus 1 (DMEM_BURST_EN only)
//   rsp_valid        one-cycle response pulse, no backpressure
//   rsp_rdata        zero-extended load data, held between pulses
//   rsp_last         final beat of the access, qualified by rsp_valid
//   mem_write_en     memory write enable
//   mem_addr         memory address
//   mem_datain       memory write data
//   mem_dataout      registered memory read data
module dmem_port_master
  import dmem_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_write,
  input  logic [AW-1:0]    req_addr,
  input  logic [N-1:0]     req_wdata,
`ifdef DMEM_BURST_EN
  input  logic [LEN_W-1:0] req_len,
`endif
  output logic             rsp_valid,
  output logic [N-1:0]     rsp_rdata,
  output logic             rsp_last,
  output logic             mem_write_en,
  output logic [AW-1:0]    mem_addr,
  output logic [N-1:0]     mem_datain,
  input  logic [DW-1:0]    mem_dataout
);

  function automatic logic [N-1:0] zext(input logic [DW-1:0] d);
    return N'(d);
  endfunction

  dmem_state_t state;

  // Read data is valid on mem_dataout the cycle after an address was issued
  // in RD_ISSUE; these flags follow that beat to the response register.
  logic rd_vld_p1;
  logic issue_last;

  assign req_ready = (state == IDLE);

`ifdef DMEM_BURST_EN
  logic [AW-1:0] burst_addr;
  logic          rd_last_p1;
  logic          load_start;

  assign load_start = (state == IDLE) && req_valid && !req_write;

  dmem_addr_gen #(
    .AW (AW)
  ) u_addr_gen (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (load_start),
    .start_addr (req_addr),
    .len        (req_len),
    .adv        (state == RD_ISSUE),
    .next_addr  (burst_addr),
    .last       (issue_last)
  );
`else
  assign issue_last = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      mem_write_en <= 1'b0;
      mem_addr     <= '0;
      mem_datain   <= '0;
      rsp_valid    <= 1'b0;
      rsp_last     <= 1'b0;
      rsp_rdata    <= '0;
      rd_vld_p1    <= 1'b0;
`ifdef DMEM_BURST_EN
      rd_last_p1   <= 1'b0;
`endif
    end else begin
      // ---- stage p1 -> response: capture returned word, complete stores
      rsp_valid <= rd_vld_p1 || (state == WRITE);
`ifdef DMEM_BURST_EN
      rsp_last  <= (rd_vld_p1 && rd_last_p1) || (state == WRITE);
      rd_last_p1 <= issue_last;
`else
      rsp_last  <= rd_vld_p1 || (state == WRITE);
`endif
      if (rd_vld_p1) rsp_rdata <= zext(mem_dataout);

      // ---- issue -> stage p1: address presented, data returns next cycle
      rd_vld_p1 <= (state == RD_ISSUE);

      mem_write_en <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            mem_addr <= req_addr;
            if (req_write) begin
              mem_datain   <= req_wdata;
              mem_write_en <= 1'b1;
              state        <= WRITE;
            end else begin
              state <= RD_ISSUE;
            end
          end
        end
        WRITE: state <= IDLE;
        RD_ISSUE: begin
          if (issue_last) begin
            state <= RD_CAPTURE;
          end else begin
`ifdef DMEM_BURST_EN
            mem_addr <= burst_addr;
`endif
            state <= RD_ISSUE;
          end
        end
        RD_CAPTURE: state <= IDLE;
        default:    state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_port_master.sv
`timescale 1ns/1ps
module tb_dmem_port_master;

  localparam int N  = 17;
  localparam int AW = 12;
  localparam int DW = 12;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_write = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [N-1:0]  req_wdata = '0;
`ifdef DMEM_BURST_EN
  logic [3:0]    req_len = '0;
`endif
  logic          rsp_valid;
  logic [N-1:0]  rsp_rdata;
  logic          rsp_last;
  logic          mem_write_en;
  logic [AW-1:0] mem_addr;
  logic [N-1:0]  mem_datain;
  logic [DW-1:0] mem_dataout;

  always #5 clk = ~clk;

  dmem_port_master #(.N(N), .AW(AW), .DW(DW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_write    (req_write),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
`ifdef DMEM_BURST_EN
    .req_len      (req_len),
`endif
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_last     (rsp_last),
    .mem_write_en (mem_write_en),
    .mem_addr     (mem_addr),
    .mem_datain   (mem_datain),
    .mem_dataout  (mem_dataout)
  );

  // Memory environment: registered read, dataout updated only on non-write edges.
  logic [DW-1:0] seed_arr [DEPTH];
  logic [DW-1:0] mem_arr  [DEPTH];
  logic          preload_go = 1'b0;

  always @(posedge clk) begin
    if (preload_go) begin
      for (int i = 0; i < DEPTH; i++) mem_arr[i] <= seed_arr[i];
      mem_dataout <= '0;
    end else if (mem_write_en) begin
      mem_arr[mem_addr] <= mem_datain[DW-1:0];
    end else begin
      mem_dataout <= mem_arr[mem_addr];
    end
  end

  // Transaction-level reference state
  logic [DW-1:0] ref_mem [DEPTH];
  logic [N-1:0]  exp_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [AW-1:0] pick_addr();
    case ($urandom_range(0, 5))
      0:       return 12'd200;
      1:       return 12'd4094;
      2:       return 12'd4095;
      3:       return 12'd0;
      4:       return AW'($urandom_range(0, 15));
      default: return AW'($urandom);
    endcase
  endfunction

  // Called at a negedge with the DUT idle; returns at the negedge of the cycle
  // in which the DUT is idle again, so a following call is back-to-back.
  task automatic run_op(input bit wr, input logic [AW-1:0] a, input logic [N-1:0] d,
                        input int len, input bit junk);
    int eff_len;
    int last_c;
    logic [AW-1:0] ea;
    eff_len = wr ? 0 : len;
`ifndef DMEM_BURST_EN
    eff_len = 0;
`endif
    last_c = wr ? 2 : eff_len + 3;
    check_eq("ready_before_req", req_ready, 1);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = a;
    req_wdata = d;
`ifdef DMEM_BURST_EN
    req_len   = 4'(len);
`endif
    @(posedge clk);
    for (int c = 1; c <= last_c; c++) begin
      @(negedge clk);
      if (wr) begin
        check_eq("st_write_en", mem_write_en, (c == 1));
        if (c == 1) begin
          check_eq("st_addr", mem_addr, a);
          check_eq("st_datain", mem_datain, d);
        end
        check_eq("st_rsp_valid", rsp_valid, (c == 2));
        if (c == 2) check_eq("st_rsp_last", rsp_last, 1);
      end else begin
        check_eq("ld_write_en", mem_write_en, 0);
        if (c <= eff_len + 1) begin
          ea = a + AW'(c - 1);
          check_eq("ld_addr", mem_addr, ea);
        end
        check_eq("ld_rsp_valid", rsp_valid, (c >= 3));
        if (c >= 3) begin
          ea = a + AW'(c - 3);
          exp_rdata = N'(ref_mem[ea]);
          check_eq("ld_rsp_last", rsp_last, (c == last_c));
        end
      end
      check_eq("rsp_rdata", rsp_rdata, exp_rdata);
      check_eq("req_ready", req_ready, (c == last_c));
      if (junk && c < last_c) begin
        req_valid = 1'($urandom);
        req_write = 1'($urandom);
        req_addr  = AW'($urandom);
        req_wdata = N'($urandom);
      end else begin
        req_valid = 1'b0;
      end
    end
    if (wr) ref_mem[a] = d[DW-1:0];
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check_eq("idle_rsp_valid", rsp_valid, 0);
      check_eq("idle_write_en", mem_write_en, 0);
      check_eq("idle_ready", req_ready, 1);
      check_eq("idle_rdata", rsp_rdata, exp_rdata);
    end
  endtask

  task automatic check_reset_outputs();
    check_eq("rst_ready", req_ready, 1);
    check_eq("rst_rsp_valid", rsp_valid, 0);
    check_eq("rst_rsp_last", rsp_last, 0);
    check_eq("rst_write_en", mem_write_en, 0);
    check_eq("rst_addr", mem_addr, 0);
    check_eq("rst_datain", mem_datain, 0);
    check_eq("rst_rdata", rsp_rdata, 0);
  endtask

  // Abort an access one cycle after acceptance with an asynchronous reset.
  task automatic reset_mid(input bit wr, input logic [AW-1:0] a, input logic [N-1:0] d);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = a;
    req_wdata = d;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check_reset_outputs();
    exp_rdata = '0;
    @(negedge clk);
    rst_n = 1'b1;
    idle(4);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      seed_arr[i] = DW'($urandom);
      if (i == 4094) seed_arr[i] = '0;
      ref_mem[i] = seed_arr[i];
    end
    exp_rdata  = '0;
    preload_go = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    preload_go = 1'b0;
    @(negedge clk);
    check_reset_outputs();
    rst_n = 1'b1;
    idle(2);

    // Store then load of the same word; upper bits of the store data are dropped.
    run_op(1'b1, 12'd200, 17'h1ABC5, 0, 1'b0);
    run_op(1'b0, 12'd200, '0, 0, 1'b0);
    check_eq("ld200_value", rsp_rdata, 17'h00BC5);
    idle(1);

    // Preloaded zero word near the top of memory.
    run_op(1'b0, 12'd4094, '0, 0, 1'b0);
    idle(1);

    // Back-to-back stores, then back-to-back loads, with ignored requests.
    run_op(1'b1, 12'd10, N'($urandom), 0, 1'b1);
    run_op(1'b1, 12'd11, N'($urandom), 0, 1'b1);
    run_op(1'b0, 12'd10, '0, 0, 1'b1);
    run_op(1'b0, 12'd11, '0, 0, 1'b1);
    idle(2);

`ifdef DMEM_BURST_EN
    // Burst that wraps past the top of the address space.
    run_op(1'b0, 12'd4094, '0, 3, 1'b0);
    idle(1);
    run_op(1'b1, 12'd4095, N'($urandom), 7, 1'b0);
    run_op(1'b0, 12'd4093, '0, 5, 1'b1);
    idle(1);
`endif

    // Reset while a load is in flight (rsp_rdata nonzero beforehand).
    run_op(1'b1, 12'd200, 17'h00777, 0, 1'b0);
    run_op(1'b0, 12'd200, '0, 0, 1'b0);
    reset_mid(1'b0, 12'd200, '0);

    // Reset during the WRITE cycle: the store must not land.
    reset_mid(1'b1, 12'd300, 17'h15A5A);
    run_op(1'b0, 12'd300, '0, 0, 1'b0);
    idle(1);

    // Randomized traffic.
    for (int k = 0; k < 200; k++) begin
      run_op(1'($urandom), pick_addr(), N'($urandom), $urandom_range(0, 15),
             1'($urandom));
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
    end
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_port_master.md
# dmem_port_master

Core-side initiator for one data-memory port. Accepts load/store requests from a core's control unit over a valid/ready handshake and drives the memory's `write_en`/`addr`/`datain` signals. It captures the registered `dataout` return and delivers it back to the core as a single-cycle response pulse. One instance sits between each core and its port on the shared data memory.

## Interface
- `N`, 17, request/response data width, matching the bus width.
- `AW`, 12, memory address width.
- `DW`, 12, memory word width (`DW` ≤ `N`).

- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  block can accept a request this cycle.
- `req_write`  in  1  1 = store, 0 = load.
- `req_addr`  in  AW  word address.
- `req_wdata`  in  N  store data. Only `[DW-1:0]` reaches memory.
- `req_len`  in  4  burst length minus 1. Present only with `DMEM_BURST_EN`.
- `rsp_valid`  out  1  single-cycle response pulse.
- `rsp_rdata`  out  N  load data, zero-extended from `DW`. Held between pulses.
- `rsp_last`  out  1  final beat of the access, qualified by `rsp_valid`.
- `mem_write_en`  out  1  to memory `write_en`.
- `mem_addr`  out  AW  to memory `addr`.
- `mem_datain`  out  N  to memory `datain`.
- `mem_dataout`  in  DW  from memory `dataout`. Registered by the memory: it reflects `mem_addr` of the previous edge and is updated only when `mem_write_en` was 0 at that edge.

## Operation
- **States:** `IDLE`, `WRITE`, `RD_ISSUE`, `RD_CAPTURE`.
- **Handshake:**
  - `req_ready` = (state == `IDLE`).
  - A request is accepted on a clock edge where `req_valid` and `req_ready` are both 1.
  - Request fields are registered at acceptance and may change afterwards.
- **IDLE:**
  - Accepted store → `WRITE`.
  - Accepted load → `RD_ISSUE`.
  - `mem_write_en` = 0 in this state.
- **WRITE:**
  - `mem_write_en` = 1, `mem_addr` = captured address, `mem_datain` = captured data.
  - Next edge → `IDLE`, with `rsp_valid` = 1 and `rsp_last` = 1 for one cycle.
  - `rsp_rdata` is unchanged by a store.
- **RD_ISSUE:**
  - `mem_write_en` = 0, `mem_addr` = captured address.
  - Next edge → `RD_CAPTURE`.
- **RD_CAPTURE:**
  - Next edge: `rsp_rdata` ← zero-extended `mem_dataout`, `rsp_valid` = 1, `rsp_last` = 1, state → `IDLE`.
- **Response side:** has no backpressure. The consumer must take the response in the pulse cycle.
- **Reset (`rst_n` low), asynchronous:**
  - Forces `IDLE`.
  - `req_ready` = 1.
  - `rsp_valid`, `rsp_last`, `mem_write_en` = 0.
  - `mem_addr`, `mem_datain`, `rsp_rdata` = 0.
- **Reset mid-operation:** any in-flight access is abandoned. A store whose `WRITE` cycle is cut by reset before its edge is not performed, and no response is issued.
- **Address arithmetic:** modulo 2^AW. Address 4095 + 1 wraps to 0.

## Timing
- Acceptance edge = end of cycle T.
- **Store:**
  - `mem_write_en` high during T+1.
  - Memory writes at the end of T+1.
  - `rsp_valid` during T+2; `req_ready` is high again in T+2.
- **Load:**
  - Address presented during T+1.
  - `mem_dataout` valid during T+2.
  - `rsp_valid` with data during T+3.
- **Throughput:** back-to-back stores are accepted every 2 cycles; back-to-back loads every 3 cycles.
- **`mem_write_en`:** never high for more than one cycle per store, and never high in any read state.

## Configuration
- **`DMEM_BURST_EN` defined:**
  - `req_len` port exists.
  - A load issues addresses A, A+1, …, A+`req_len` (wrapping) on consecutive cycles in `RD_ISSUE`. A beat counter decides when to move to `RD_CAPTURE`.
  - Responses arrive on consecutive cycles from T+3 through T+3+`req_len`.
  - `rsp_last` is set only on the final beat.
  - `req_len` is ignored for stores.
- **`DMEM_BURST_EN` undefined:** no `req_len` port; every access is a single beat; `rsp_last` is always 1 with `rsp_valid`.

## Structure
- **Package `dmem_pkg`:**
  - `AW`/`DW` defaults.
  - The state enum typedef (`IDLE`, `WRITE`, `RD_ISSUE`, `RD_CAPTURE`).
  - The burst-length width constant (4).
- **Sub-module `dmem_addr_gen`:**
  - Burst address incrementer and beat counter, with wrap at 2^AW and a `last` flag.
  - Instantiated only under `DMEM_BURST_EN`.

## Test plan
- **Reset:** assert `rst_n`=0 mid-load at T+1 → all outputs read 0 except `req_ready`=1; no `rsp_valid` afterwards.
- **Store then load:** store addr 12'd200, data 17'h1ABC5 → `mem_write_en` pulses 1 cycle with `mem_datain`=17'h1ABC5. Then load addr 200 → `rsp_rdata`=17'h00BC5 at T+3.
- **Preloaded load:** load addr 12'd4094 on a memory preloaded with 0 → `rsp_valid` at exactly T+3 with `rsp_rdata`=0 and `rsp_last`=1.
- **Back-to-back stores:** `req_valid` held high with two stores → second acceptance 2 cycles after the first; `req_ready`=0 during each `WRITE` cycle.
- **Wrapping burst (`DMEM_BURST_EN`):** load addr 12'd4094, `req_len`=3 → `mem_addr` sequence 4094, 4095, 0, 1; four consecutive `rsp_valid` beats; `rsp_last` only on the fourth.
- **Ignored inputs:** `req_valid` pulsed while state ≠ `IDLE` → request ignored; no extra `mem_write_en` and no extra response.
